bus_master: RTL and testbench



---
 rtl/bus_master_pkg.sv | 36 +++
 rtl/bus_timer.sv | 31 +++
 rtl/bus_master.sv | 146 ++++++++++++++
 tb/tb_bus_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared register-bus field layout and bus_in packing helper
package bus_master_pkg;

    localparam int BUS_ADDR_WIDTH    = 16;
    localparam int BUS_DATA_WIDTH    = 32;

    localparam int BUS_FIELD_CLK     = 0;
    localparam int BUS_FIELD_RESET   = 1;
    localparam int BUS_FIELD_ADDR    = 2;
    localparam int BUS_FIELD_WR_DATA = BUS_FIELD_ADDR + BUS_ADDR_WIDTH;
    localparam int BUS_FIELD_WE      = BUS_FIELD_WR_DATA + BUS_DATA_WIDTH;
    localparam int BUS_FIELD_RE      = BUS_FIELD_WE + 1;
    localparam int BUS_IN_WIDTH      = BUS_FIELD_RE + 1;

    localparam int BUS_RD_DATA_LSB   = 0;
    localparam int BUS_RD_DATA_MSB   = BUS_DATA_WIDTH - 1;
    localparam int BUS_FIELD_RD_ACK  = BUS_DATA_WIDTH;
    localparam int BUS_FIELD_WR_ACK  = BUS_FIELD_RD_ACK + 1;
    localparam int BUS_FIELD_IRQ     = BUS_FIELD_WR_ACK + 1;
    localparam int BUS_OUT_WIDTH     = BUS_FIELD_IRQ + 1;

    localparam int BUS_TIMER_WIDTH   = 16;

    // Concatenation order must track the BUS_FIELD_* offsets above.
    function automatic logic [BUS_IN_WIDTH-1:0] pack_bus_in(
        input logic                      clk,
        input logic                      reset_l,
        input logic [BUS_ADDR_WIDTH-1:0] addr,
        input logic [BUS_DATA_WIDTH-1:0] wr_data,
        input logic                      we,
        input logic                      re
    );
        pack_bus_in = {re, we, wr_data, addr, reset_l, clk};
    endfunction

endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - loadable up-counter with terminal flag for ack timeouts
module bus_timer
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic bus_clk,
    input  logic bus_reset_l,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam logic [BUS_TIMER_WIDTH-1:0] TERMINAL = BUS_TIMER_WIDTH'(TIMEOUT - 1);

    logic [BUS_TIMER_WIDTH-1:0] count;

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + BUS_TIMER_WIDTH'(1);
        end
    end

    // Terminal on the TIMEOUT-th WAIT cycle, since the count starts at zero.
    assign done = (count == TERMINAL);

endmodule

// File: rtl/bus_master.sv
// rtl/bus_master.sv - single-outstanding register-bus master with ack timeout
module bus_master
    import bus_master_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                      bus_clk,
    input  logic                      bus_reset_l,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [BUS_DATA_WIDTH-1:0] req_wr_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BUS_DATA_WIDTH-1:0] rsp_rd_data,
    output logic                      rsp_err,
    output logic                      irq,
    output logic [BUS_IN_WIDTH-1:0]   bus_in,
    input  logic [BUS_OUT_WIDTH-1:0]  bus_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [BUS_ADDR_WIDTH-1:0] addr_q;
    logic [BUS_DATA_WIDTH-1:0] wr_data_q;
    logic                      write_q;
    logic                      we_q;
    logic                      re_q;

    logic                      accept;
    logic                      finish_ok;
    logic                      finish_to;
    logic                      rsp_take;
    logic                      timer_load;
    logic                      timer_inc;
    logic                      timer_done;

    logic [BUS_DATA_WIDTH-1:0] bus_rd_data;
    logic                      bus_rd_ack;
    logic                      bus_wr_ack;
    logic                      ack_match;

    assign bus_rd_data = bus_out[BUS_RD_DATA_MSB:BUS_RD_DATA_LSB];
    assign bus_rd_ack  = bus_out[BUS_FIELD_RD_ACK];
    assign bus_wr_ack  = bus_out[BUS_FIELD_WR_ACK];
    assign ack_match   = write_q ? bus_wr_ack : bus_rd_ack;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .load        (timer_load),
        .inc         (timer_inc),
        .done        (timer_done)
    );

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = ack_match ? S_RESP : S_WAIT;
            S_WAIT:  if (ack_match || timer_done) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A matching ack always takes priority over a coincident timeout.
    always_comb begin
        accept     = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        rsp_take   = 1'b0;
        timer_load = 1'b0;
        timer_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                accept     = req_valid;
                timer_load = req_valid;
            end
            S_ISSUE: finish_ok = ack_match;
            S_WAIT: begin
                timer_inc = 1'b1;
                finish_ok = ack_match;
                finish_to = !ack_match && timer_done;
            end
            S_RESP:  rsp_take = rsp_ready;
            default: ;
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            addr_q      <= '0;
            wr_data_q   <= '0;
            write_q     <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rd_data <= '0;
            irq         <= 1'b0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (accept) begin
                addr_q    <= req_addr;
                wr_data_q <= req_wr_data;
                write_q   <= req_write;
                we_q      <= req_write;
                re_q      <= !req_write;
            end
            if (finish_ok) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b0;
                rsp_rd_data <= write_q ? '0 : bus_rd_data;
            end else if (finish_to) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_rd_data <= '0;
            end else if (rsp_take) begin
                rsp_valid   <= 1'b0;
            end
            irq <= bus_out[BUS_FIELD_IRQ];
        end
    end

    assign req_ready = (state == S_IDLE);
    assign bus_in    = pack_bus_in(bus_clk, bus_reset_l, addr_q, wr_data_q, we_q, re_q);

endmodule

// File: tb/tb_bus_master.sv
// tb/tb_bus_master.sv - directed bench for bus_master with a bus_reg slave and response model
module tb_bus_master;
    import bus_master_pkg::*;

    localparam int TIMEOUT = 8;

    logic                      bus_clk     = 1'b0;
    logic                      bus_reset_l = 1'b1;
    logic                      req_valid   = 1'b0;
    logic                      req_write   = 1'b0;
    logic [BUS_ADDR_WIDTH-1:0] req_addr    = '0;
    logic [BUS_DATA_WIDTH-1:0] req_wr_data = '0;
    logic                      rsp_ready   = 1'b0;
    logic                      req_ready;
    logic                      rsp_valid;
    logic                      rsp_err;
    logic                      irq;
    logic [BUS_DATA_WIDTH-1:0] rsp_rd_data;
    logic [BUS_IN_WIDTH-1:0]   bus_in;
    logic [BUS_OUT_WIDTH-1:0]  bus_out;

    logic                      inj_rd_ack = 1'b0;
    logic                      inj_wr_ack = 1'b0;
    logic [BUS_DATA_WIDTH-1:0] inj_data   = '0;
    logic                      irq_drv    = 1'b0;

    logic                      sl_rd_ack;
    logic                      sl_wr_ack;
    logic [BUS_DATA_WIDTH-1:0] sl_rd_data;
    logic [BUS_DATA_WIDTH-1:0] slave_reg;

    logic                      bus_we;
    logic                      bus_re;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [BUS_DATA_WIDTH-1:0] bus_wdata;

    typedef struct packed {
        logic                      err;
        logic [BUS_DATA_WIDTH-1:0] data;
    } rsp_t;

    rsp_t                      exp_q[$];
    logic                      busy;
    logic                      irq_prev;
    logic [BUS_DATA_WIDTH-1:0] model_reg;

    int vectors     = 0;
    int miscompares = 0;

    bus_master #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd_data (rsp_rd_data),
        .rsp_err     (rsp_err),
        .irq         (irq),
        .bus_in      (bus_in),
        .bus_out     (bus_out)
    );

    always #5 bus_clk = ~bus_clk;

    assign bus_we    = bus_in[BUS_FIELD_WE];
    assign bus_re    = bus_in[BUS_FIELD_RE];
    assign bus_addr  = bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH];
    assign bus_wdata = bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH];
    assign bus_out   = {irq_drv, sl_wr_ack | inj_wr_ack, sl_rd_ack | inj_rd_ack, sl_rd_data | inj_data};

    // Registered bus_reg slave at word 0x10.
    always @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            sl_rd_ack  <= 1'b0;
            sl_wr_ack  <= 1'b0;
            sl_rd_data <= '0;
            slave_reg  <= 32'hA5A5_A5A5;
        end else begin
            sl_rd_ack  <= bus_re && (bus_addr == 16'h0010);
            sl_wr_ack  <= bus_we && (bus_addr == 16'h0010);
            sl_rd_data <= (bus_re && (bus_addr == 16'h0010)) ? slave_reg : '0;
            if (bus_we && (bus_addr == 16'h0010)) slave_reg <= bus_wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response rules: the only mapped register is 0x10; anything else times out.
    task automatic model_req(input logic wr, input logic [BUS_ADDR_WIDTH-1:0] a,
                             input logic [BUS_DATA_WIDTH-1:0] d, output rsp_t e, output int lat);
        if (a == 16'h0010) begin
            e.err = 1'b0;
            lat   = 3;
            if (wr) begin
                model_reg = d;
                e.data    = '0;
            end else begin
                e.data = model_reg;
            end
        end else begin
            e.err  = 1'b1;
            e.data = '0;
            lat    = TIMEOUT + 2;
        end
    endtask

    always @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            busy     <= 1'b0;
            irq_prev <= 1'b0;
            exp_q.delete();
        end else begin
            irq_prev <= irq_drv;
            if (!busy && req_valid) begin
                busy <= 1'b1;
            end else if (busy && rsp_valid && rsp_ready) begin
                busy <= 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge bus_clk) begin
        if (bus_reset_l) begin
            check("req_ready", 64'(req_ready), 64'(!busy));
            check("strobe_excl", 64'(bus_we & bus_re), 64'd0);
            check("irq", 64'(irq), 64'(irq_prev));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 64'(rsp_valid), 64'd0);
                end else begin
                    check("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
                    check("rsp_rd_data", 64'(rsp_rd_data), 64'(exp_q[0].data));
                end
            end
        end
    end

    task automatic run_req(input string tag, input logic wr, input logic [BUS_ADDR_WIDTH-1:0] addr,
                           input logic [BUS_DATA_WIDTH-1:0] data, input int hold, input bit inject);
        rsp_t e;
        int   lat;
        int   got_lat = 0;
        int   strobes = 0;
        if (inject) begin
            e.err  = 1'b0;
            e.data = 32'hDEAD_BEEF;
            lat    = 5;
        end else begin
            model_req(wr, addr, data, e, lat);
        end
        exp_q.push_back(e);
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = addr;
        req_wr_data = data;
        @(posedge bus_clk);
        @(negedge bus_clk);
        req_valid = 1'b0;
        for (int k = 1; k <= TIMEOUT + 20; k++) begin
            if (inject) begin
                inj_wr_ack = (k == 2);
                inj_rd_ack = (k == 4);
                inj_data   = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
            end
            if (k == 1) begin
                check({tag, " we"}, 64'(bus_we), 64'(wr));
                check({tag, " re"}, 64'(bus_re), 64'(!wr));
                check({tag, " addr"}, 64'(bus_addr), 64'(addr));
                if (wr) check({tag, " wdata"}, 64'(bus_wdata), 64'(data));
            end
            strobes += int'(bus_we) + int'(bus_re);
            if (rsp_valid) begin
                got_lat = k;
                break;
            end
            @(negedge bus_clk);
        end
        check({tag, " latency"}, 64'(got_lat), 64'(lat));
        check({tag, " strobes"}, 64'(strobes), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge bus_clk);
            check({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
            check({tag, " hold strobe"}, 64'(bus_we | bus_re), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge bus_clk);
        @(negedge bus_clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rsp_t e;
        int   lat;
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t pin_e;
        int   pin_lat;
        model_reg = 32'hA5A5_A5A5;
        #1 bus_reset_l = 1'b0;
        repeat (3) @(negedge bus_clk);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_err", 64'(rsp_err), 64'd0);
        check("rst rsp_rd_data", 64'(rsp_rd_data), 64'd0);
        check("rst bus fields", 64'(bus_in[BUS_IN_WIDTH-1:BUS_FIELD_RESET]), 64'd0);
        #2 bus_reset_l = 1'b1;
        @(negedge bus_clk);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst reset field", 64'(bus_in[BUS_FIELD_RESET]), 64'd1);

        model_req(1'b0, 16'h0010, 32'h0, pin_e, pin_lat);
        check("pin read data", 64'(pin_e.data), 64'h0000_0000_A5A5_A5A5);
        check("pin read lat", 64'(pin_lat), 64'd3);
        model_req(1'b0, 16'h0020, 32'h0, pin_e, pin_lat);
        check("pin timeout lat", 64'(pin_lat), 64'd10);
        check("pin timeout err", 64'(pin_e.err), 64'd1);

        run_req("rd_a5", 1'b0, 16'h0010, 32'h0, 0, 1'b0);
        run_req("wr", 1'b1, 16'h0010, 32'h1234_5678, 0, 1'b0);
        run_req("rdback", 1'b0, 16'h0010, 32'h0, 0, 1'b0);
        run_req("timeout", 1'b0, 16'h0020, 32'h0, 0, 1'b0);
        run_req("hold", 1'b0, 16'h0010, 32'h0, 5, 1'b0);
        irq_drv = 1'b1;
        run_req("wrong_ack", 1'b0, 16'h0020, 32'h0, 0, 1'b1);
        irq_drv = 1'b0;

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0020;
        @(posedge bus_clk);
        @(negedge bus_clk);
        req_valid = 1'b0;
        repeat (2) @(negedge bus_clk);
        #2 bus_reset_l = 1'b0;
        #1;
        check("wait_rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("wait_rst rd_data", 64'(rsp_rd_data), 64'd0);
        check("wait_rst err", 64'(rsp_err), 64'd0);
        check("wait_rst irq", 64'(irq), 64'd0);
        check("wait_rst bus fields", 64'(bus_in[BUS_IN_WIDTH-1:BUS_FIELD_RESET]), 64'd0);
        @(negedge bus_clk);
        #2 bus_reset_l = 1'b1;
        model_reg = 32'hA5A5_A5A5;
        for (int i = 0; i < TIMEOUT + 6; i++) begin
            @(negedge bus_clk);
            check("wait_rst no rsp", 64'(rsp_valid), 64'd0);
        end
        run_req("post_rst", 1'b0, 16'h0010, 32'h0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
